// File: rtl/dmem_port_arbiter_pkg.sv
// Shared types and defaults for the DMEM port arbiter slice.
// Optional perf counters are enabled with `define ARB_PERF_CNT_EN.
package dmem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_P,
    ARB_D_LOCK
  } arb_owner_e;

  // Requester that owns the memory command in the current cycle
  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_P,
    SEL_D
  } arb_sel_e;

  localparam int unsigned ARB_STARVE_MAX_DEF = 4;
  localparam int unsigned ARB_MAX_BURST_DEF  = 8;
  localparam int unsigned ARB_PERF_W         = 32;

  // Bits needed to hold values 0..max_val, never less than one
  function automatic int unsigned arb_cnt_width(input int unsigned max_val);
    int unsigned w;
    w = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((max_val >> i) != 0) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// Request/grant/memory bus between processor, loader, DMEM and the arbiter.
// slave = arbiter side, master = requesters/memory side.
interface dmem_port_arbiter_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  logic          p_req_i;
  logic [AW-1:0] p_addr_i;
  logic [DW-1:0] p_wdata_i;
  logic [3:0]    p_we_i;
  logic          p_re_i;
  logic          p_stall_o;
  logic          p_rvalid_o;

  logic          d_req_i;
  logic          d_lock_i;
  logic [AW-1:0] d_addr_i;
  logic [DW-1:0] d_wdata_i;
  logic [3:0]    d_we_i;
  logic          d_re_i;
  logic          d_gnt_o;
  logic          d_rvalid_o;

  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic [3:0]    mem_we_o;
  logic          mem_re_o;
  logic [DW-1:0] mem_rdata_i;

  modport slave (
    input  p_req_i, p_addr_i, p_wdata_i, p_we_i, p_re_i,
    input  d_req_i, d_lock_i, d_addr_i, d_wdata_i, d_we_i, d_re_i,
    input  mem_rdata_i,
    output p_stall_o, p_rvalid_o, d_gnt_o, d_rvalid_o,
    output mem_addr_o, mem_wdata_o, mem_we_o, mem_re_o
  );

  modport master (
    output p_req_i, p_addr_i, p_wdata_i, p_we_i, p_re_i,
    output d_req_i, d_lock_i, d_addr_i, d_wdata_i, d_we_i, d_re_i,
    output mem_rdata_i,
    input  p_stall_o, p_rvalid_o, d_gnt_o, d_rvalid_o,
    input  mem_addr_o, mem_wdata_o, mem_we_o, mem_re_o
  );
endinterface

// File: rtl/dmem_port_arbiter_sat_counter.sv
// Saturating up-counter with synchronous reset and clear (clear wins over increment).
module arb_sat_counter #(
  parameter int unsigned   W   = 8,
  parameter logic [W-1:0]  MAX = '1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_count
);
  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != MAX)) begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_count = r_count;
endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares the DMEM port between processor (P, fixed priority) and loader (D, starvation-forced, lockable bursts).
// Define ARB_PERF_CNT_EN to add saturating P-stall and forced-D-grant counters.
module dmem_port_arbiter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int unsigned AW         = 32,
  parameter int unsigned DW         = 32,
  parameter int unsigned STARVE_MAX = ARB_STARVE_MAX_DEF,
  parameter int unsigned MAX_BURST  = ARB_MAX_BURST_DEF
) (
  input logic clk,
  input logic rst,
  dmem_port_arbiter_if.slave bus
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [ARB_PERF_W-1:0] perf_p_stall_o,
  output logic [ARB_PERF_W-1:0] perf_d_force_o
`endif
);
  localparam int unsigned   SW         = arb_cnt_width(STARVE_MAX);
  localparam int unsigned   BW         = arb_cnt_width(MAX_BURST - 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
  localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);
  localparam bit            BURST_EN   = (MAX_BURST > 1);

  arb_owner_e    r_owner;
  arb_owner_e    w_owner_nxt;
  arb_sel_e      w_sel;
  logic          w_p_req;
  logic          w_d_req;
  logic          w_force;
  logic          w_p_stall;
  logic [SW-1:0] r_starve;
  logic [BW-1:0] r_burst;
  logic          r_p_rvalid;
  logic          r_d_rvalid;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_wdata;

  // Accesses with neither read nor write are not requests; reset masks everything
  assign w_p_req = !rst && bus.p_req_i && (bus.p_re_i || (bus.p_we_i != '0));
  assign w_d_req = !rst && bus.d_req_i && (bus.d_re_i || (bus.d_we_i != '0));
  assign w_force = w_d_req && (r_starve == STARVE_LIM);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner <= ARB_IDLE;
    end else begin
      r_owner <= w_owner_nxt;
    end
  end

  always_comb begin
    w_sel       = SEL_NONE;
    w_owner_nxt = r_owner;
    case (r_owner)
      ARB_IDLE, ARB_P: begin
        if (w_force)      w_sel = SEL_D;
        else if (w_p_req) w_sel = SEL_P;
        else if (w_d_req) w_sel = SEL_D;

        if (w_sel == SEL_D && bus.d_lock_i && BURST_EN) w_owner_nxt = ARB_D_LOCK;
        else if (w_sel == SEL_P)                        w_owner_nxt = ARB_P;
        else                                            w_owner_nxt = ARB_IDLE;
      end
      ARB_D_LOCK: begin
        // Only a still-locked D beat is served; any drop ends the burst without a grant
        if (w_d_req && bus.d_lock_i) begin
          w_sel       = SEL_D;
          w_owner_nxt = (r_burst == BURST_LAST) ? ARB_IDLE : ARB_D_LOCK;
        end else begin
          w_owner_nxt = ARB_IDLE;
        end
      end
      default: w_owner_nxt = ARB_IDLE;
    endcase
    if (rst) begin
      w_sel       = SEL_NONE;
      w_owner_nxt = ARB_IDLE;
    end
  end

  arb_sat_counter #(.W(SW), .MAX(STARVE_LIM)) u_starve (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (!w_d_req || (w_sel == SEL_D)),
    .i_inc   (w_d_req && (w_sel != SEL_D)),
    .o_count (r_starve)
  );

  // Every cycle that stays in (or enters) the lock is a granted D beat
  arb_sat_counter #(.W(BW), .MAX(BURST_LAST)) u_burst (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (w_owner_nxt != ARB_D_LOCK),
    .i_inc   (w_owner_nxt == ARB_D_LOCK),
    .o_count (r_burst)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_p_rvalid <= 1'b0;
      r_d_rvalid <= 1'b0;
    end else begin
      r_p_rvalid <= (w_sel == SEL_P) && bus.p_re_i;
      r_d_rvalid <= (w_sel == SEL_D) && bus.d_re_i;
    end
  end

  assign w_p_stall = w_p_req && (w_sel != SEL_P);
  assign w_addr    = (w_sel == SEL_D) ? bus.d_addr_i  : bus.p_addr_i;
  assign w_wdata   = (w_sel == SEL_D) ? bus.d_wdata_i : bus.p_wdata_i;

  always_comb begin
    bus.p_stall_o   = w_p_stall;
    bus.d_gnt_o     = (w_sel == SEL_D);
    bus.p_rvalid_o  = r_p_rvalid;
    bus.d_rvalid_o  = r_d_rvalid;
    bus.mem_addr_o  = w_addr;
    bus.mem_wdata_o = w_wdata;
    bus.mem_we_o    = '0;
    bus.mem_re_o    = 1'b0;
    case (w_sel)
      SEL_P: begin
        bus.mem_we_o = bus.p_we_i;
        bus.mem_re_o = bus.p_re_i;
      end
      SEL_D: begin
        bus.mem_we_o = bus.d_we_i;
        bus.mem_re_o = bus.d_re_i;
      end
      default: ;
    endcase
  end

`ifdef ARB_PERF_CNT_EN
  logic w_forced_gnt;
  assign w_forced_gnt = w_force && (w_sel == SEL_D) && (r_owner != ARB_D_LOCK);

  arb_sat_counter #(.W(ARB_PERF_W)) u_perf_stall (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (1'b0),
    .i_inc   (w_p_stall),
    .o_count (perf_p_stall_o)
  );

  arb_sat_counter #(.W(ARB_PERF_W)) u_perf_force (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (1'b0),
    .i_inc   (w_forced_gnt),
    .o_count (perf_d_force_o)
  );
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed + randomized bench for dmem_port_arbiter against a behavioural reference model.
module tb_dmem_port_arbiter;
  localparam int unsigned SMAX = 4;
  localparam int unsigned MB   = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dmem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

`ifdef ARB_PERF_CNT_EN
  logic [31:0] perf_p_stall;
  logic [31:0] perf_d_force;
`endif

  dmem_port_arbiter #(.AW(32), .DW(32), .STARVE_MAX(SMAX), .MAX_BURST(MB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef ARB_PERF_CNT_EN
    ,
    .perf_p_stall_o (perf_p_stall),
    .perf_d_force_o (perf_d_force)
`endif
  );

  int checks = 0;
  int errors = 0;

  // reference model state
  int unsigned m_wait  = 0;   // consecutive cycles D has waited
  int unsigned m_beats = 0;   // beats taken in current locked burst (0 = no burst)
  bit          m_p_rv  = 0;
  bit          m_d_rv  = 0;
  int unsigned m_perf_stall = 0;
  int unsigned m_perf_force = 0;

  // observed DUT activity for scenario-level checks
  int unsigned obs_dgnt   = 0;
  int unsigned obs_pstall = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.p_req_i = 0; bus.p_re_i = 0; bus.p_we_i = '0;
    bus.d_req_i = 0; bus.d_re_i = 0; bus.d_we_i = '0; bus.d_lock_i = 0;
  endtask

  // One clock: check outputs mid-cycle against the model, then advance the model at the edge
  task automatic cycle();
    bit pr, dr, pg, dg, frc, in_burst, lock;
    logic [3:0] exp_we;
    bit exp_re;
    #2;
    pr = !rst && bus.p_req_i && (bus.p_re_i || bus.p_we_i != 4'd0);
    dr = !rst && bus.d_req_i && (bus.d_re_i || bus.d_we_i != 4'd0);
    lock = bus.d_lock_i;
    in_burst = (m_beats > 0);
    pg = 0; dg = 0; frc = 0;
    if (in_burst)                     dg = dr && lock;
    else if (dr && m_wait >= SMAX)    begin dg = 1; frc = 1; end
    else if (pr)                      pg = 1;
    else if (dr)                      dg = 1;

    exp_we = pg ? bus.p_we_i : (dg ? bus.d_we_i : 4'd0);
    exp_re = pg ? bus.p_re_i : (dg ? bus.d_re_i : 1'b0);
    chk("p_stall",   32'(bus.p_stall_o),  32'(pr && !pg));
    chk("d_gnt",     32'(bus.d_gnt_o),    32'(dg));
    chk("mem_we",    32'(bus.mem_we_o),   32'(exp_we));
    chk("mem_re",    32'(bus.mem_re_o),   32'(exp_re));
    chk("mem_addr",  bus.mem_addr_o,      dg ? bus.d_addr_i : bus.p_addr_i);
    chk("mem_wdata", bus.mem_wdata_o,     dg ? bus.d_wdata_i : bus.p_wdata_i);
    chk("p_rvalid",  32'(bus.p_rvalid_o), 32'(m_p_rv));
    chk("d_rvalid",  32'(bus.d_rvalid_o), 32'(m_d_rv));
`ifdef ARB_PERF_CNT_EN
    chk("perf_p_stall", perf_p_stall, m_perf_stall);
    chk("perf_d_force", perf_d_force, m_perf_force);
`endif
    if (bus.d_gnt_o === 1'b1)   obs_dgnt++;
    if (bus.p_stall_o === 1'b1) obs_pstall++;

    @(posedge clk);
    if (rst) begin
      m_wait = 0; m_beats = 0; m_p_rv = 0; m_d_rv = 0;
      m_perf_stall = 0; m_perf_force = 0;
    end else begin
      m_p_rv = pg && bus.p_re_i;
      m_d_rv = dg && bus.d_re_i;
      if (dr && !dg) m_wait = (m_wait < SMAX) ? m_wait + 1 : SMAX;
      else           m_wait = 0;
      if (in_burst)                  m_beats = (dg && m_beats + 1 < MB) ? m_beats + 1 : 0;
      else if (dg && lock && MB > 1) m_beats = 1;
      if (pr && !pg) m_perf_stall++;
      if (frc)       m_perf_force++;
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    bus.p_addr_i = '0; bus.p_wdata_i = '0; bus.d_addr_i = '0; bus.d_wdata_i = '0;
    bus.mem_rdata_i = '0;
    @(negedge clk);

    // reset with requests pending: nothing may be granted
    bus.p_req_i = 1; bus.p_re_i = 1; bus.d_req_i = 1; bus.d_re_i = 1;
    cycle();
    cycle();
    rst = 0;
    idle_inputs();
    cycle();

    // P read alone
    bus.p_req_i = 1; bus.p_re_i = 1; bus.p_addr_i = 32'h10;
    cycle();
    chk("s1_addr_seen", 32'(obs_pstall), 32'd0);
    idle_inputs();
    cycle();

    // P and D both requesting every cycle: D forced every fifth cycle
    obs_dgnt = 0; obs_pstall = 0;
    bus.p_req_i = 1; bus.p_re_i = 1; bus.p_addr_i = 32'h40;
    bus.d_req_i = 1; bus.d_re_i = 1; bus.d_addr_i = 32'h80;
    for (int i = 0; i < 10; i++) cycle();
    chk("s2_d_gnts", 32'(obs_dgnt), 32'd2);
    chk("s2_p_stalls", 32'(obs_pstall), 32'd2);
    idle_inputs();
    cycle();

    // D alone, locked, 12 cycles: continuous grants across the burst boundary
    obs_dgnt = 0;
    bus.d_req_i = 1; bus.d_lock_i = 1; bus.d_re_i = 1; bus.d_addr_i = 32'h300;
    for (int i = 0; i < 12; i++) begin bus.d_addr_i = 32'h300 + 32'(4 * i); cycle(); end
    chk("s3_d_gnts", 32'(obs_dgnt), 32'd12);
    idle_inputs();
    cycle();

    // P arrives at beat 4 of a burst: stalls until the 8-beat burst ends
    bus.d_req_i = 1; bus.d_lock_i = 1; bus.d_re_i = 1;
    for (int i = 0; i < 3; i++) cycle();
    obs_pstall = 0;
    bus.p_req_i = 1; bus.p_re_i = 1; bus.p_addr_i = 32'h20;
    for (int i = 0; i < 7; i++) cycle();
    chk("s3_p_stalls", 32'(obs_pstall), 32'd5);
    idle_inputs();
    cycle();

    // D byte write while P idle, then quiet cycle
    bus.d_req_i = 1; bus.d_we_i = 4'b0011; bus.d_addr_i = 32'h200; bus.d_wdata_i = 32'hCAFE_1234;
    cycle();
    idle_inputs();
    cycle();

    // reset at burst beat 3, then P must win at once
    bus.d_req_i = 1; bus.d_lock_i = 1; bus.d_re_i = 1;
    cycle(); cycle();
    rst = 1;
    cycle();
    rst = 0;
    bus.p_req_i = 1; bus.p_re_i = 1; bus.p_addr_i = 32'h44;
    obs_pstall = 0;
    cycle();
    chk("s5_p_after_rst", 32'(obs_pstall), 32'd0);
    cycle();
    idle_inputs();
    cycle();

    // randomized traffic, including no-op requests and occasional reset
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(63) == 0);
      bus.p_req_i   = ($urandom_range(9) < 6);
      bus.p_re_i    = $urandom_range(1);
      bus.p_we_i    = ($urandom_range(3) == 0) ? 4'($urandom) : 4'd0;
      bus.p_addr_i  = $urandom;
      bus.p_wdata_i = $urandom;
      bus.d_req_i   = ($urandom_range(9) < 5);
      bus.d_lock_i  = ($urandom_range(9) < 7);
      bus.d_re_i    = $urandom_range(1);
      bus.d_we_i    = ($urandom_range(3) == 0) ? 4'($urandom) : 4'd0;
      bus.d_addr_i  = $urandom;
      bus.d_wdata_i = $urandom;
      bus.mem_rdata_i = $urandom;
      cycle();
    end
    rst = 0;
    idle_inputs();
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
